// File: rtl/mpu6050_pkg.sv
// Shared constants and types for the MPU6050 sequencer back end.
package mpu6050_pkg;

  localparam int unsigned NUM_AXES  = 3;
  localparam int unsigned NUM_SLOTS = 6;

  localparam int unsigned ADR_XH = 0;
  localparam int unsigned ADR_XL = 1;
  localparam int unsigned ADR_YH = 2;
  localparam int unsigned ADR_YL = 3;
  localparam int unsigned ADR_ZH = 4;
  localparam int unsigned ADR_ZL = 5;

  localparam logic [NUM_SLOTS-1:0] FULL_MASK = 6'b111111;

  typedef enum logic [1:0] {COLLECT, CHECK, EMIT} filt_state_t;

endpackage

// File: rtl/axis_accumulator.sv
// One axis: sign-extending accumulator with clear and arithmetic-shift divide.
module axis_accumulator #(
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned DATA_W   = 16
) (
  input  logic              MCLK,
  input  logic              RESET,
  input  logic              add_en,
  input  logic              clr_en,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] avg_c
);

  localparam int unsigned ACC_W = DATA_W + AVG_LOG2;

  logic signed [ACC_W-1:0] acc_q;

  always_ff @(posedge MCLK) begin
    if (RESET || clr_en) begin
      acc_q <= '0;
    end else if (add_en) begin
      acc_q <= acc_q + ACC_W'($signed(sample));
    end
  end

  // Shift of a signed accumulator floors toward -inf.
  assign avg_c = DATA_W'(acc_q >>> AVG_LOG2);

endmodule

// File: rtl/accel_frame_filter.sv
// Assembles X/Y/Z frames from the sequencer byte stream, drops incomplete
// frames and box-averages 2^AVG_LOG2 good frames onto a valid/ready output.
module accel_frame_filter
  import mpu6050_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned DATA_W   = 16
) (
  input  logic              MCLK,
  input  logic              RESET,
  input  logic              TIC,
  input  logic              LOAD,
  input  logic [3:0]        ADR,
  input  logic [7:0]        DATA,
  input  logic              COMPLETED,
  output logic [DATA_W-1:0] X_AVG,
  output logic [DATA_W-1:0] Y_AVG,
  output logic [DATA_W-1:0] Z_AVG,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              FRAME_ERR,
  output logic              OVERRUN
);

  localparam int unsigned CNT_W    = AVG_LOG2 + 1;
  localparam int unsigned LAST_CNT = (1 << AVG_LOG2) - 1;

  logic [7:0]           slot_q     [NUM_SLOTS];
  logic [7:0]           slot_nxt_c [NUM_SLOTS];
  logic [7:0]           frame_q    [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] mask_q;
  logic [NUM_SLOTS-1:0] mask_nxt_c;
  logic [NUM_SLOTS-1:0] frame_mask_q;
  filt_state_t          state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 add_c;
  logic                 clr_c;
  logic [DATA_W-1:0]    avg_c      [NUM_AXES];

  // Live slots with this cycle's byte merged, so a closing byte joins its frame.
  always_comb begin
    slot_nxt_c = slot_q;
    mask_nxt_c = mask_q;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (TIC && LOAD && (ADR == 4'(i))) begin
        slot_nxt_c[i] = DATA;
        mask_nxt_c[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i]  <= '0;
        frame_q[i] <= '0;
      end
      mask_q       <= '0;
      frame_mask_q <= '0;
    end else begin
      slot_q <= slot_nxt_c;
      if (TIC && COMPLETED) begin
        frame_q      <= slot_nxt_c;
        frame_mask_q <= mask_nxt_c;
        mask_q       <= '0;
      end else begin
        mask_q <= mask_nxt_c;
      end
    end
  end

  assign add_c = (state_q == CHECK) && (frame_mask_q == FULL_MASK);
  assign clr_c = (state_q == EMIT);

  for (genvar g = 0; g < NUM_AXES; g++) begin : g_axis
    axis_accumulator #(
      .AVG_LOG2 (AVG_LOG2),
      .DATA_W   (DATA_W)
    ) u_acc (
      .MCLK   (MCLK),
      .RESET  (RESET),
      .add_en (add_c),
      .clr_en (clr_c),
      .sample ({frame_q[ADR_XH + 2*g], frame_q[ADR_XH + 2*g + 1]}),
      .avg_c  (avg_c[g])
    );
  end

  // Frame check / emit sequencing and output handshake.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state_q   <= COLLECT;
      cnt_q     <= '0;
      X_AVG     <= '0;
      Y_AVG     <= '0;
      Z_AVG     <= '0;
      OUT_VALID <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
      if (OUT_VALID && OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
      case (state_q)
        COLLECT: begin
          if (TIC && COMPLETED) begin
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (frame_mask_q != FULL_MASK) begin
            FRAME_ERR <= 1'b1;
            state_q   <= COLLECT;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= (cnt_q == CNT_W'(LAST_CNT)) ? EMIT : COLLECT;
          end
        end
        EMIT: begin
          X_AVG     <= avg_c[0];
          Y_AVG     <= avg_c[1];
          Z_AVG     <= avg_c[2];
          OUT_VALID <= 1'b1;
          OVERRUN   <= OUT_VALID && !OUT_READY;
          cnt_q     <= '0;
          state_q   <= COLLECT;
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_frame_filter.sv
// Drives the same byte stream into AVG_LOG2=0 and AVG_LOG2=2 filters and
// compares both against a frame-level averaging model.
module tb_accel_frame_filter;

  logic        mclk = 1'b0;
  logic        rst = 1'b1;
  logic        tic = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  adr = '0;
  logic [7:0]  data = '0;
  logic        completed = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] x_avg [2];
  logic [15:0] y_avg [2];
  logic [15:0] z_avg [2];
  logic        out_valid [2];
  logic        frame_err [2];
  logic        overrun [2];

  int n_checks = 0;
  int n_fail = 0;

  always #5 mclk = ~mclk;

  accel_frame_filter #(.AVG_LOG2(0)) dut0 (
    .MCLK(mclk), .RESET(rst), .TIC(tic), .LOAD(load), .ADR(adr), .DATA(data),
    .COMPLETED(completed), .X_AVG(x_avg[0]), .Y_AVG(y_avg[0]), .Z_AVG(z_avg[0]),
    .OUT_VALID(out_valid[0]), .OUT_READY(out_ready), .FRAME_ERR(frame_err[0]),
    .OVERRUN(overrun[0])
  );

  accel_frame_filter #(.AVG_LOG2(2)) dut2 (
    .MCLK(mclk), .RESET(rst), .TIC(tic), .LOAD(load), .ADR(adr), .DATA(data),
    .COMPLETED(completed), .X_AVG(x_avg[1]), .Y_AVG(y_avg[1]), .Z_AVG(z_avg[1]),
    .OUT_VALID(out_valid[1]), .OUT_READY(out_ready), .FRAME_ERR(frame_err[1]),
    .OVERRUN(overrun[1])
  );

  // Pulse and rising-edge counters observed once per cycle.
  int   ferr_cnt [2] = '{0, 0};
  int   ovr_cnt  [2] = '{0, 0};
  int   rise_cnt [2] = '{0, 0};
  logic prev_v   [2] = '{1'b0, 1'b0};

  always @(negedge mclk) begin
    for (int i = 0; i < 2; i++) begin
      if (frame_err[i] === 1'b1) ferr_cnt[i]++;
      if (overrun[i] === 1'b1) ovr_cnt[i]++;
      if (out_valid[i] === 1'b1 && prev_v[i] !== 1'b1) rise_cnt[i]++;
      prev_v[i] = out_valid[i];
    end
  end

  // Reference model state
  logic [7:0]  m_slot [6];
  logic [5:0]  m_mask;
  int          m_cnt [2];
  int          m_sum [2][3];
  logic [15:0] m_out [2][3];
  logic        m_valid [2];
  int          m_ferr = 0;
  int          m_ovr [2] = '{0, 0};
  int          m_rise [2] = '{0, 0};

  function automatic int n_frames(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int floor_div(int s, int n);
    return (s >= 0) ? s / n : -((-s + n - 1) / n);
  endfunction

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic model_reset();
    m_mask = '0;
    for (int a = 0; a < 6; a++) m_slot[a] = '0;
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0;
      m_valid[i] = 1'b0;
      for (int a = 0; a < 3; a++) begin
        m_sum[i][a] = 0;
        m_out[i][a] = '0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic model_byte(input bit tic_v, input bit load_v, input logic [3:0] a, input logic [7:0] d);
    if (tic_v && load_v && a < 4'd6) begin
      m_slot[a] = d;
      m_mask[a] = 1'b1;
    end
  endtask

  task automatic model_close();
    int s;
    if (m_mask != 6'b111111) begin
      m_ferr++;
    end else begin
      for (int i = 0; i < 2; i++) begin
        for (int a = 0; a < 3; a++) begin
          s = int'($signed({m_slot[2*a], m_slot[2*a+1]}));
          m_sum[i][a] += s;
        end
        m_cnt[i]++;
        if (m_cnt[i] == n_frames(i)) begin
          for (int a = 0; a < 3; a++) begin
            m_out[i][a] = 16'(floor_div(m_sum[i][a], n_frames(i)));
            m_sum[i][a] = 0;
          end
          if (m_valid[i] && !out_ready) m_ovr[i]++;
          if (!m_valid[i]) m_rise[i]++;
          m_valid[i] = 1'b1;
          m_cnt[i] = 0;
        end
      end
    end
    m_mask = '0;
  endtask

  task automatic put_byte(input bit tic_v, input logic [3:0] a, input logic [7:0] d);
    tic = tic_v; load = 1'b1; adr = a; data = d;
    step();
    tic = 1'b0; load = 1'b0;
    model_byte(tic_v, 1'b1, a, d);
    repeat (2) step();
  endtask

  // vh records OUT_VALID of the AVG_LOG2=0 instance after each following edge.
  task automatic close_frame(input bit with_load, input logic [3:0] a, input logic [7:0] d,
                             output logic [2:0] vh);
    tic = 1'b1; completed = 1'b1; load = with_load; adr = a; data = d;
    step();
    tic = 1'b0; completed = 1'b0; load = 1'b0;
    model_byte(1'b1, with_load, a, d);
    model_close();
    for (int k = 0; k < 3; k++) begin
      step();
      vh[k] = out_valid[0];
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) m_valid[i] = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                            input int drop, input bit merge, input bit junk);
    logic [7:0] b [6];
    int q[$];
    int last, r, t;
    logic [2:0] vh;
    b = '{x[15:8], x[7:0], y[15:8], y[7:0], z[15:8], z[7:0]};
    for (int a = 0; a < 6; a++) if (a != drop) q.push_back(a);
    for (int j = q.size() - 1; j > 0; j--) begin
      r = int'($urandom_range(j, 0));
      t = q[j]; q[j] = q[r]; q[r] = t;
    end
    if (junk) put_byte(1'b1, 4'(6 + $urandom_range(9, 0)), 8'($urandom));
    if (merge && q.size() > 0) begin
      last = q.pop_back();
      foreach (q[j]) put_byte(1'b1, 4'(q[j]), b[q[j]]);
      close_frame(1'b1, 4'(last), b[last], vh);
    end else begin
      foreach (q[j]) put_byte(1'b1, 4'(q[j]), b[q[j]]);
      close_frame(1'b0, 4'd0, 8'd0, vh);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({x_avg[i], y_avg[i], z_avg[i], out_valid[i], frame_err[i], overrun[i]} !== 51'd0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got x=%h y=%h z=%h v=%b fe=%b ov=%b, expected all zero",
                 i, x_avg[i], y_avg[i], z_avg[i], out_valid[i], frame_err[i], overrun[i]);
      end
    end
  endtask

  task automatic test_basic();
    logic [2:0] vh;
    do_reset();
    put_byte(1'b1, 4'd0, 8'h12); put_byte(1'b1, 4'd1, 8'h34);
    put_byte(1'b1, 4'd2, 8'hFF); put_byte(1'b1, 4'd3, 8'hFE);
    put_byte(1'b1, 4'd4, 8'h40); put_byte(1'b1, 4'd5, 8'h00);
    close_frame(1'b0, 4'd0, 8'd0, vh);
    n_checks++;
    if (vh !== 3'b110) begin
      n_fail++;
      $display("FAIL basic latency: valid history %b, expected 110", vh);
    end
    n_checks++;
    if ({x_avg[0], y_avg[0], z_avg[0]} !== {16'h1234, 16'hFFFE, 16'h4000}) begin
      n_fail++;
      $display("FAIL basic value: got %h %h %h, expected 1234 fffe 4000", x_avg[0], y_avg[0], z_avg[0]);
    end
    repeat (5) step();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({x_avg[i], y_avg[i], z_avg[i], out_valid[i]} !== {m_out[i][0], m_out[i][1], m_out[i][2], m_valid[i]}) begin
        n_fail++;
        $display("FAIL basic out[%0d]: got %h %h %h v=%b, expected %h %h %h v=%b", i, x_avg[i], y_avg[i],
                 z_avg[i], out_valid[i], m_out[i][0], m_out[i][1], m_out[i][2], m_valid[i]);
      end
    end
  endtask

  task automatic test_average();
    logic [15:0] tx [4] = '{16'd100, 16'd101, 16'd102, 16'd104};
    logic [15:0] ty [4] = '{16'hFFFD, 16'hFFFD, 16'hFFFD, 16'hFFFE};
    int base;
    do_reset();
    base = rise_cnt[1];
    for (int f = 0; f < 4; f++) send_frame(tx[f], ty[f], 16'h8000, 6, 1'($urandom_range(1, 0)), 1'b0);
    n_checks++;
    if ({x_avg[1], y_avg[1], z_avg[1], out_valid[1]} !== {16'd101, 16'hFFFD, 16'h8000, 1'b1}) begin
      n_fail++;
      $display("FAIL average value: got %h %h %h v=%b, expected 0065 fffd 8000 v=1",
               x_avg[1], y_avg[1], z_avg[1], out_valid[1]);
    end
    n_checks++;
    if (rise_cnt[1] - base !== 1) begin
      n_fail++;
      $display("FAIL average valid count: got %0d rises, expected 1", rise_cnt[1] - base);
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({ferr_cnt[i], ovr_cnt[i], rise_cnt[i]} !== {m_ferr, m_ovr[i], m_rise[i]}) begin
        n_fail++;
        $display("FAIL average events[%0d]: got fe=%0d ov=%0d r=%0d, expected fe=%0d ov=%0d r=%0d",
                 i, ferr_cnt[i], ovr_cnt[i], rise_cnt[i], m_ferr, m_ovr[i], m_rise[i]);
      end
    end
  endtask

  task automatic test_frame_err();
    do_reset();
    send_frame(16'h0102, 16'h0304, 16'h0506, 5, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({ferr_cnt[i], out_valid[i]} !== {m_ferr, 1'b0}) begin
        n_fail++;
        $display("FAIL frame_err[%0d]: got fe=%0d v=%b, expected fe=%0d v=0", i, ferr_cnt[i], out_valid[i], m_ferr);
      end
    end
    for (int f = 0; f < 4; f++)
      send_frame(16'($urandom), 16'($urandom), 16'($urandom), 6, 1'($urandom_range(1, 0)), 1'b1);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({x_avg[i], y_avg[i], z_avg[i], out_valid[i], ferr_cnt[i], ovr_cnt[i]} !==
          {m_out[i][0], m_out[i][1], m_out[i][2], m_valid[i], m_ferr, m_ovr[i]}) begin
        n_fail++;
        $display("FAIL frame_err avg[%0d]: got %h %h %h v=%b fe=%0d ov=%0d, expected %h %h %h v=%b fe=%0d ov=%0d",
                 i, x_avg[i], y_avg[i], z_avg[i], out_valid[i], ferr_cnt[i], ovr_cnt[i],
                 m_out[i][0], m_out[i][1], m_out[i][2], m_valid[i], m_ferr, m_ovr[i]);
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    send_frame(16'd5, 16'd0, 16'd0, 6, 1'b0, 1'b0);
    send_frame(16'd7, 16'd0, 16'd0, 6, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({x_avg[i], out_valid[i], ovr_cnt[i], rise_cnt[i]} !== {m_out[i][0], m_valid[i], m_ovr[i], m_rise[i]}) begin
        n_fail++;
        $display("FAIL overrun[%0d]: got x=%h v=%b ov=%0d r=%0d, expected x=%h v=%b ov=%0d r=%0d", i, x_avg[i],
                 out_valid[i], ovr_cnt[i], rise_cnt[i], m_out[i][0], m_valid[i], m_ovr[i], m_rise[i]);
      end
    end
    consume();
    n_checks++;
    if (out_valid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun consume: got valid=%b, expected 0", out_valid[0]);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    send_frame(16'h1111, 16'h2222, 16'h3333, 6, 1'b0, 1'b0);
    put_byte(1'b1, 4'd0, 8'hAB); put_byte(1'b1, 4'd1, 8'hCD); put_byte(1'b1, 4'd2, 8'hEF);
    do_reset();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({x_avg[i], y_avg[i], z_avg[i], out_valid[i], frame_err[i], overrun[i]} !== 51'd0) begin
        n_fail++;
        $display("FAIL midreset[%0d]: got x=%h y=%h z=%h v=%b fe=%b ov=%b, expected all zero",
                 i, x_avg[i], y_avg[i], z_avg[i], out_valid[i], frame_err[i], overrun[i]);
      end
    end
    send_frame(16'hF00D, 16'h0042, 16'h8001, 6, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({x_avg[i], y_avg[i], z_avg[i], out_valid[i], ferr_cnt[i]} !==
          {m_out[i][0], m_out[i][1], m_out[i][2], m_valid[i], m_ferr}) begin
        n_fail++;
        $display("FAIL midreset frame[%0d]: got %h %h %h v=%b fe=%0d, expected %h %h %h v=%b fe=%0d", i,
                 x_avg[i], y_avg[i], z_avg[i], out_valid[i], ferr_cnt[i],
                 m_out[i][0], m_out[i][1], m_out[i][2], m_valid[i], m_ferr);
      end
    end
  endtask

  task automatic test_capture_quirks();
    logic [2:0] vh;
    int base;
    do_reset();
    base = ferr_cnt[0];
    put_byte(1'b0, 4'd0, 8'hAA);
    put_byte(1'b1, 4'd9, 8'h55);
    put_byte(1'b1, 4'd0, 8'h11);
    put_byte(1'b1, 4'd0, 8'h22);
    put_byte(1'b1, 4'd1, 8'h33); put_byte(1'b1, 4'd2, 8'h44);
    put_byte(1'b1, 4'd3, 8'h55); put_byte(1'b1, 4'd4, 8'h66);
    close_frame(1'b1, 4'd5, 8'h77, vh);
    n_checks++;
    if ({x_avg[0], z_avg[0], out_valid[0]} !== {16'h2233, 16'h6677, 1'b1}) begin
      n_fail++;
      $display("FAIL quirks value: got x=%h z=%h v=%b, expected x=2233 z=6677 v=1", x_avg[0], z_avg[0], out_valid[0]);
    end
    n_checks++;
    if (ferr_cnt[0] - base !== 0) begin
      n_fail++;
      $display("FAIL quirks frame_err: got %0d pulses, expected 0", ferr_cnt[0] - base);
    end
  endtask

  task automatic test_random();
    int drop;
    do_reset();
    for (int f = 0; f < 16; f++) begin
      drop = ($urandom_range(4, 0) == 0) ? int'($urandom_range(5, 0)) : 6;
      send_frame(16'($urandom), 16'($urandom), 16'($urandom), drop,
                 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if ({x_avg[i], y_avg[i], z_avg[i], out_valid[i], ferr_cnt[i], ovr_cnt[i], rise_cnt[i]} !==
            {m_out[i][0], m_out[i][1], m_out[i][2], m_valid[i], m_ferr, m_ovr[i], m_rise[i]}) begin
          n_fail++;
          $display("FAIL random f%0d[%0d]: got %h %h %h v=%b fe=%0d ov=%0d r=%0d, expected %h %h %h v=%b fe=%0d ov=%0d r=%0d",
                   f, i, x_avg[i], y_avg[i], z_avg[i], out_valid[i], ferr_cnt[i], ovr_cnt[i], rise_cnt[i],
                   m_out[i][0], m_out[i][1], m_out[i][2], m_valid[i], m_ferr, m_ovr[i], m_rise[i]);
        end
      end
      if ($urandom_range(1, 0) == 1) consume();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_average();
    test_frame_err();
    test_overrun();
    test_reset_midframe();
    test_capture_quirks();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/accel_frame_filter.md
Name: accel_frame_filter

Overview:
- Sits directly downstream of the MPU6050 register sequencer, in parallel with the existing byte registers feeding COMPARE.
- Consumes the sequencer's TIC-qualified byte stream (LOAD/ADR/DATA) and its COMPLETED frame marker.
- Assembles signed 16-bit X/Y/Z acceleration samples and validates each frame.
- Box-averages 2^AVG_LOG2 good frames and presents the result on a valid/ready output with overrun reporting.

Parameters:
AVG_LOG2, 2, log2 of frames per average (0..4); 0 passes every frame through unfiltered
DATA_W, 16, sample width; fixed at 16, do not override

Ports:
MCLK  input  1  system clock
RESET  input  1  synchronous, active-high reset
TIC  input  1  sequencer clock-enable strobe; all inputs below are sampled only when TIC=1
LOAD  input  1  byte-valid from sequencer
ADR  input  4  register index: 0=XH 1=XL 2=YH 3=YL 4=ZH 5=ZL
DATA  input  8  register byte
COMPLETED  input  1  end-of-scan marker from sequencer
X_AVG  output  16  signed averaged X
Y_AVG  output  16  signed averaged Y
Z_AVG  output  16  signed averaged Z
OUT_VALID  output  1  result available
OUT_READY  input  1  consumer accepts result
FRAME_ERR  output  1  one-cycle pulse: incomplete frame discarded
OVERRUN  output  1  one-cycle pulse: unconsumed result overwritten

Behaviour:
- Reset (RESET=1 at a MCLK edge):
  - All outputs go to 0.
  - Byte registers, received mask, accumulators and frame count are cleared.
  - FSM goes to COLLECT.
  - Any partial frame or pending result is dropped.
- Byte capture (runs independently of FSM state):
  - On TIC & LOAD with ADR in 0..5, the byte is written to its slot and mask bit ADR is set.
  - ADR 6..15 is ignored.
  - A repeated ADR overwrites the earlier byte; last byte wins.
  - LOAD without TIC is ignored.
- Frame close, on TIC & COMPLETED:
  - If LOAD is also asserted that cycle, its byte counts toward the closing frame.
  - Otherwise, the six slots plus the full mask are snapshotted into frame registers.
  - The live mask is then cleared, so the next frame can begin on the very next TIC.
- FSM:
  - COLLECT: wait for the frame close, then go to CHECK.
  - CHECK (1 cycle):
    - Mask incomplete (≠6'b111111): pulse FRAME_ERR and return to COLLECT. Accumulators and count are unchanged.
    - Mask complete: form the samples {H,L} as signed 16-bit, add them sign-extended into 16+AVG_LOG2-bit accumulators, and increment count.
    - If count reaches 2^AVG_LOG2, go to EMIT; otherwise return to COLLECT.
  - EMIT (1 cycle):
    - Load each output with accumulator >>> AVG_LOG2 (arithmetic shift, rounds toward −inf).
    - Clear accumulators and count, assert OUT_VALID, return to COLLECT.
- Latency: results are visible in the second cycle after the closing TIC edge, i.e. the cycle after EMIT.
- TIC spacing of ≥3 cycles is guaranteed by the top level (divider ≥160), so CHECK/EMIT never coincide with the next frame close.
- Output handshake:
  - A transfer occurs when OUT_VALID & OUT_READY at a MCLK edge; OUT_VALID then falls unless EMIT loads in the same cycle.
  - X/Y/Z_AVG are stable while OUT_VALID=1 and not transferred.
- EMIT while OUT_VALID=1 and OUT_READY=0:
  - Data is replaced and OUT_VALID stays 1.
  - OVERRUN pulses for one cycle.
- EMIT while OUT_VALID=1 and OUT_READY=1: the old result is consumed, the new one loads, no OVERRUN.
- Accumulator width of 16+AVG_LOG2 guarantees no overflow; 2^AVG_LOG2 × (−32768) is representable.
- FRAME_ERR and OVERRUN are never asserted outside CHECK/EMIT respectively.

Decomposition:
- Shared package mpu6050_pkg:
  - ADR constants ADR_XH..ADR_ZL.
  - NUM_AXES=3.
  - FSM state enum {COLLECT, CHECK, EMIT}.
  - FULL_MASK=6'b111111.
- One natural sub-module, axis_accumulator: per-axis sign-extend, accumulate, clear and shift-divide, instantiated three times.
- Capture logic, FSM and handshake stay in the top module.

Test Plan:
1. AVG_LOG2=0; bytes XH=12 XL=34 YH=FF YL=FE ZH=40 ZL=00 then COMPLETED -> X=0x1234, Y=0xFFFE (−2), Z=0x4000; OUT_VALID rises 2 cycles after the COMPLETED TIC; hold OUT_READY=0 -> data stable.
2. AVG_LOG2=2; four good frames X=100,101,102,104, Y=−3,−3,−3,−2, Z=−32768×4 -> X=101, Y=−3 (−11>>>2), Z=0x8000; exactly one OUT_VALID assertion after frame 4.
3. Frame missing ZL, then COMPLETED -> FRAME_ERR one-cycle pulse, no OUT_VALID; the next four good frames (AVG_LOG2=2) produce the average of those four only.
4. AVG_LOG2=0; two frames X=5 then X=7 with OUT_READY=0 -> OVERRUN pulse at the second EMIT, X_AVG=7, OUT_VALID still 1; OUT_READY=1 for one cycle -> OUT_VALID=0 next cycle.
5. RESET asserted after XH/XL/YH captured and with OUT_VALID pending -> all outputs 0 next edge; a subsequent full frame (AVG_LOG2=0) yields correct values and no FRAME_ERR.
6. LOAD with TIC=0 (ADR=0, DATA=AA), ADR=9 bytes, duplicate XH (11 then 22), and ZL with LOAD+COMPLETED on the same TIC -> X high byte=0x22, AA ignored, frame accepted and ZL included.
